// File: rtl/dcsformer_frame_sched.sv
// ----------------------------------------------------------------------------
// dcsformer_frame_sched: round-robin frame scheduler sharing one DCSformer
// datapath between NUM_REQ byte-stream requesters.              Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dcsformer_frame_sched #(
  parameter int NUM_REQ   = 2,
  parameter int I_BYTES   = 128,
  parameter int W_BYTES   = 8,
  parameter int O_WORDS   = 8,
  parameter int W_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   i_valid,
  output logic [7:0]             i_data,
  output logic                   w_valid,
  output logic [7:0]             w_data,
  input  logic                   w_ready,
  input  logic                   o_valid,
  input  logic [31:0]            o_data,
  output logic                   res_valid,
  output logic [31:0]            res_data,
  output logic [1:0]             res_id,
  output logic                   busy,
  output logic                   frame_done,
  output logic [1:0]             err
);

  typedef enum logic [2:0] {
    ST_ARB     = 3'd0,
    ST_FEED_I  = 3'd1,
    ST_WAIT_W  = 3'd2,
    ST_FEED_W  = 3'd3,
    ST_COLLECT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  out_cnt_q, out_cnt_d;
  logic [9:0]  wait_cnt_q, wait_cnt_d;
  logic        i_valid_q, i_valid_d;
  logic [7:0]  i_data_q, i_data_d;
  logic        w_valid_q, w_valid_d;
  logic [7:0]  w_data_q, w_data_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic [1:0]  res_id_q, res_id_d;
  logic        frame_done_q, frame_done_d;
  logic [1:0]  err_q, err_d;

  logic        w_feeding;
  logic        w_sel_valid;
  logic [7:0]  w_sel_data;
  logic        w_accept;
  logic        w_gnt_found;
  logic [1:0]  w_gnt_idx;
  logic [9:0]  w_wait_inc;

  // Ready depends only on state and owner so a requester can never loop
  // its valid back into its own ready.
  always_comb begin
    w_feeding   = (state_q == ST_FEED_I) || (state_q == ST_FEED_W);
    req_ready   = '0;
    w_sel_valid = 1'b0;
    w_sel_data  = 8'd0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (owner_q == 2'(r)) begin
        req_ready[r] = w_feeding;
        w_sel_valid  = req_valid[r];
        w_sel_data   = req_data[8*r +: 8];
      end
    end
    w_accept = w_feeding && w_sel_valid;
  end

  // Round-robin search starting one past the previous winner, with wrap.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = last_grant_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!w_gnt_found && req_valid[r] &&
            (r == (int'(last_grant_q) + k) % NUM_REQ)) begin
          w_gnt_found = 1'b1;
          w_gnt_idx   = 2'(r);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    out_cnt_d    = out_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    i_valid_d    = 1'b0;
    i_data_d     = i_data_q;
    w_valid_d    = 1'b0;
    w_data_d     = w_data_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    w_wait_inc   = wait_cnt_q + 10'd1;

    // Stray handshakes from the datapath are flagged and otherwise dropped.
    if (w_ready && (state_q != ST_WAIT_W)) err_d[0] = 1'b1;
    if (o_valid && (state_q != ST_COLLECT)) err_d[0] = 1'b1;

    case (state_q)
      ST_ARB: begin
        if (w_gnt_found) begin
          owner_d      = w_gnt_idx;
          last_grant_d = w_gnt_idx;
          byte_cnt_d   = 8'd0;
          out_cnt_d    = 4'd0;
          wait_cnt_d   = 10'd0;
          state_d      = ST_FEED_I;
        end
      end
      ST_FEED_I: begin
        if (w_accept) begin
          i_valid_d = 1'b1;
          i_data_d  = w_sel_data;
          if (byte_cnt_q == 8'(I_BYTES - 1)) begin
            byte_cnt_d = 8'd0;
            wait_cnt_d = 10'd0;
            state_d    = ST_WAIT_W;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      ST_WAIT_W: begin
        if (w_ready) begin
          wait_cnt_d = 10'd0;
          state_d    = ST_FEED_W;
        end else if (w_wait_inc == 10'(W_TIMEOUT)) begin
          // Frame is abandoned; the datapath must be reset by the system.
          err_d[1]   = 1'b1;
          wait_cnt_d = 10'd0;
          state_d    = ST_ARB;
        end else begin
          wait_cnt_d = w_wait_inc;
        end
      end
      ST_FEED_W: begin
        if (w_accept) begin
          w_valid_d = 1'b1;
          w_data_d  = w_sel_data;
          if (byte_cnt_q == 8'(W_BYTES - 1)) begin
            byte_cnt_d = 8'd0;
            out_cnt_d  = 4'd0;
            state_d    = ST_COLLECT;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      ST_COLLECT: begin
        if (o_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = o_data;
          res_id_d    = owner_q;
          if (out_cnt_q == 4'(O_WORDS - 1)) begin
            out_cnt_d    = 4'd0;
            frame_done_d = 1'b1;
            state_d      = ST_ARB;
          end else begin
            out_cnt_d = out_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ARB;
      owner_q      <= 2'd0;
      last_grant_q <= 2'(NUM_REQ - 1);
      byte_cnt_q   <= 8'd0;
      out_cnt_q    <= 4'd0;
      wait_cnt_q   <= 10'd0;
      i_valid_q    <= 1'b0;
      i_data_q     <= 8'd0;
      w_valid_q    <= 1'b0;
      w_data_q     <= 8'd0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 32'd0;
      res_id_q     <= 2'd0;
      frame_done_q <= 1'b0;
      err_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      out_cnt_q    <= out_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      i_valid_q    <= i_valid_d;
      i_data_q     <= i_data_d;
      w_valid_q    <= w_valid_d;
      w_data_q     <= w_data_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign i_valid    = i_valid_q;
  assign i_data     = i_data_q;
  assign w_valid    = w_valid_q;
  assign w_data     = w_data_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_id     = res_id_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_ARB);

endmodule

`default_nettype wire
